led_rate_decoder: RTL

//  Receive-side decoder for the LED blink drive. Measures the half-period of a

---
 rtl/led_rate_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_rate_decoder.sv
// Receive-side blink decoder: measures the half-period of i_led and recovers the
// 2-bit rate select that produced it; flags "stopped" when the input holds still.
module led_rate_decoder #(
  parameter int unsigned C_HP_SEL11  = 125000000,
  parameter int unsigned C_HP_SEL10  = 12500000,
  parameter int unsigned C_HP_SEL01  = 2500000,
  parameter int unsigned C_HP_SEL00  = 25000000,
  parameter int unsigned C_TOL_SHIFT = 4,
  parameter int unsigned C_MATCH     = 2,
  parameter int unsigned C_TIMEOUT   = 150000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_led,
  output logic [1:0]  o_sel,
  output logic        o_valid,
  output logic        o_stopped,
  output logic        o_level,
  output logic        o_change,
  output logic [31:0] o_period
);

  typedef enum logic [1:0] {ST_ACQUIRE, ST_MEASURE, ST_LOCKED} state_e;

  localparam logic [31:0] LO11    = 32'(C_HP_SEL11 - (C_HP_SEL11 >> C_TOL_SHIFT));
  localparam logic [31:0] HI11    = 32'(C_HP_SEL11 + (C_HP_SEL11 >> C_TOL_SHIFT));
  localparam logic [31:0] LO10    = 32'(C_HP_SEL10 - (C_HP_SEL10 >> C_TOL_SHIFT));
  localparam logic [31:0] HI10    = 32'(C_HP_SEL10 + (C_HP_SEL10 >> C_TOL_SHIFT));
  localparam logic [31:0] LO01    = 32'(C_HP_SEL01 - (C_HP_SEL01 >> C_TOL_SHIFT));
  localparam logic [31:0] HI01    = 32'(C_HP_SEL01 + (C_HP_SEL01 >> C_TOL_SHIFT));
  localparam logic [31:0] LO00    = 32'(C_HP_SEL00 - (C_HP_SEL00 >> C_TOL_SHIFT));
  localparam logic [31:0] HI00    = 32'(C_HP_SEL00 + (C_HP_SEL00 >> C_TOL_SHIFT));
  localparam logic [31:0] TIMEOUT = 32'(C_TIMEOUT);
  localparam logic [31:0] MATCH   = 32'(C_MATCH);

  state_e      state_q, state_d;
  logic        led_s1_q, led_s2_q, led_s3_q;
  logic [31:0] cnt_q, cnt_d;
  logic [1:0]  cand_q, cand_d;
  logic [31:0] match_q, match_d;
  logic [1:0]  sel_q, sel_d;
  logic        valid_q, valid_d;
  logic        stopped_q, stopped_d;
  logic        change_q, change_d;
  logic [31:0] period_q, period_d;

  logic        edge_pulse, timeout_hit;
  logic        cls_hit, lock_hit, same_lock;
  logic [1:0]  cls;
  logic [31:0] interval, match_next;

  assign edge_pulse  = led_s2_q ^ led_s3_q;
  assign interval    = cnt_q + 32'd1;
  assign timeout_hit = !edge_pulse && (cnt_q == TIMEOUT - 32'd1);
  // While locked cand_q equals sel_q, so a different class always restarts at 1.
  assign match_next  = (cls == cand_q) ? match_q + 32'd1 : 32'd1;
  assign lock_hit    = cls_hit && (match_next >= MATCH);
  assign same_lock   = cls_hit && (state_q == ST_LOCKED) && (cls == sel_q);

  always_comb begin
    cls_hit = 1'b1;
    cls     = 2'b00;
    if (interval >= LO11 && interval <= HI11)      cls = 2'b11;
    else if (interval >= LO10 && interval <= HI10) cls = 2'b10;
    else if (interval >= LO01 && interval <= HI01) cls = 2'b01;
    else if (interval >= LO00 && interval <= HI00) cls = 2'b00;
    else                                           cls_hit = 1'b0;
  end

  always_comb begin
    if (edge_pulse)           cnt_d = '0;
    else if (cnt_q < TIMEOUT) cnt_d = cnt_q + 32'd1;
    else                      cnt_d = cnt_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_ACQUIRE;
      led_s1_q  <= 1'b0;
      led_s2_q  <= 1'b0;
      led_s3_q  <= 1'b0;
      cnt_q     <= '0;
      cand_q    <= '0;
      match_q   <= '0;
      sel_q     <= '0;
      valid_q   <= 1'b0;
      stopped_q <= 1'b0;
      change_q  <= 1'b0;
      period_q  <= '0;
    end else begin
      state_q   <= state_d;
      led_s1_q  <= i_led;
      led_s2_q  <= led_s1_q;
      led_s3_q  <= led_s2_q;
      cnt_q     <= cnt_d;
      cand_q    <= cand_d;
      match_q   <= match_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      stopped_q <= stopped_d;
      change_q  <= change_d;
      period_q  <= period_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (edge_pulse) begin
      case (state_q)
        ST_ACQUIRE: state_d = ST_MEASURE;
        ST_MEASURE: if (lock_hit) state_d = ST_LOCKED;
        ST_LOCKED:  if (!same_lock) state_d = lock_hit ? ST_LOCKED : ST_MEASURE;
        default:    state_d = ST_ACQUIRE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_ACQUIRE;
    end
  end

  always_comb begin
    cand_d    = cand_q;
    match_d   = match_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    stopped_d = stopped_q;
    change_d  = 1'b0;
    period_d  = period_q;
    if (edge_pulse) begin
      stopped_d = 1'b0;
      if (state_q == ST_ACQUIRE) begin
        match_d = '0;
      end else begin
        period_d = interval;
        if (!cls_hit) begin
          match_d = '0;
          valid_d = 1'b0;
        end else if (!same_lock) begin
          cand_d  = cls;
          match_d = match_next;
          valid_d = 1'b0;
          if (lock_hit) begin
            valid_d  = 1'b1;
            sel_d    = cls;
            change_d = 1'b1;
          end
        end
      end
    end else if (timeout_hit) begin
      valid_d   = 1'b0;
      stopped_d = 1'b1;
      match_d   = '0;
    end
  end

  assign o_sel     = sel_q;
  assign o_valid   = valid_q;
  assign o_stopped = stopped_q;
  assign o_level   = led_s2_q;
  assign o_change  = change_q;
  assign o_period  = period_q;

endmodule
